// File: rtl/async_op_pkg.sv
// Shared operation codes and legal parameter ranges for the buffered async operator.
package async_op_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUBI = 3'd2,
    OP_MULI = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6
  } op_e;

  localparam int MIN_INPUT_SIZE  = 1;
  localparam int MAX_INPUT_SIZE  = 3;
  localparam int MIN_OUTPUT_SIZE = 1;
  localparam int MAX_OUTPUT_SIZE = 8;
  localparam int MIN_DEPTH       = 2;

  // Fold operations need at least two operands to be meaningful.
  function automatic bit op_is_fold(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/async_op_alu.sv
// Combinational operator: unary ops against IMMEDIATE, or a left fold over all operands.
module async_op_alu
  import async_op_pkg::*;
#(
  parameter op_e                   OP         = OP_PASS,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0,
  parameter int                    INPUT_SIZE = 1
) (
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] operands_i,
  output logic [DATA_WIDTH-1:0]            result_o
);

  always_comb begin
    result_o = operands_i[DATA_WIDTH-1:0];
    case (OP)
      OP_ADDI: result_o = operands_i[DATA_WIDTH-1:0] + IMMEDIATE;
      OP_SUBI: result_o = operands_i[DATA_WIDTH-1:0] - IMMEDIATE;
      OP_MULI: result_o = operands_i[DATA_WIDTH-1:0] * IMMEDIATE;
      OP_ADD: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result_o = result_o + operands_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_SUB: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result_o = result_o - operands_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_MUL: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result_o = result_o * operands_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/async_operator_buffered.sv
// Request/ack operand collector feeding an ALU and a multi-reader result buffer.
// Optional ASYNC_OP_STATS_EN adds saturating fire_count / stall_count outputs.
module async_operator_buffered
  import async_op_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter op_e                   OP          = OP_PASS,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
  parameter int                    INPUT_SIZE  = 1,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout
`ifdef ASYNC_OP_STATS_EN
  ,
  output logic [31:0]                       fire_count,
  output logic [31:0]                       stall_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  if (INPUT_SIZE < MIN_INPUT_SIZE || INPUT_SIZE > MAX_INPUT_SIZE) begin : g_bad_input_size
    $error("async_operator_buffered: INPUT_SIZE out of range");
  end
  if (OUTPUT_SIZE < MIN_OUTPUT_SIZE || OUTPUT_SIZE > MAX_OUTPUT_SIZE) begin : g_bad_output_size
    $error("async_operator_buffered: OUTPUT_SIZE out of range");
  end
  if (DEPTH < MIN_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("async_operator_buffered: DEPTH must be a power of two >= 2");
  end
  if (op_is_fold(OP) && INPUT_SIZE < 2) begin : g_bad_op
    $error("async_operator_buffered: fold operation needs INPUT_SIZE >= 2");
  end

  logic [INPUT_SIZE-1:0]             req_l_q, req_l_d;
  logic [INPUT_SIZE-1:0]             has_q, has_d;
  logic [DATA_WIDTH*INPUT_SIZE-1:0]  opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]             mem_q [DEPTH];
  logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                     rd_ptr_q [OUTPUT_SIZE];
  logic [PW-1:0]                     rd_ptr_d [OUTPUT_SIZE];
  logic [CW-1:0]                     occ_q [OUTPUT_SIZE];
  logic [CW-1:0]                     occ_d [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0]            ack_r_q, ack_r_d, pop;
  logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0]             alu_res;
  logic                              all_has, full, fire;

  async_op_alu #(
    .OP         (OP),
    .DATA_WIDTH (DATA_WIDTH),
    .IMMEDIATE  (IMMEDIATE),
    .INPUT_SIZE (INPUT_SIZE)
  ) u_alu (
    .operands_i (opnd_q),
    .result_o   (alu_res)
  );

  // Full is judged on registered occupancy, so a pop only makes room next cycle.
  always_comb begin
    all_has = &has_q;
    full    = 1'b0;
    for (int j = 0; j < OUTPUT_SIZE; j++)
      if (occ_q[j] == CW'(DEPTH)) full = 1'b1;
    fire = all_has && !full;
  end

  always_comb begin
    req_l_d = req_l_q;
    has_d   = has_q;
    opnd_d  = opnd_q;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (ack_l[i] && req_l_q[i]) begin
        has_d[i]                            = 1'b1;
        req_l_d[i]                          = 1'b0;
        opnd_d[i*DATA_WIDTH +: DATA_WIDTH]  = din[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (!has_q[i] && !req_l_q[i]) begin
        req_l_d[i] = 1'b1;
      end
    end
    if (fire) has_d = '0;
  end

  always_comb begin
    wr_ptr_d = fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    ack_r_d  = '0;
    pop      = '0;
    dout_d   = dout_q;
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      pop[j]      = req_r[j] && !ack_r_q[j] && (occ_q[j] != '0);
      ack_r_d[j]  = pop[j];
      rd_ptr_d[j] = rd_ptr_q[j];
      occ_d[j]    = occ_q[j];
      if (pop[j]) begin
        dout_d[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q[j]];
        rd_ptr_d[j]                        = rd_ptr_q[j] + 1'b1;
      end
      case ({fire, pop[j]})
        2'b10:   occ_d[j] = occ_q[j] + 1'b1;
        2'b01:   occ_d[j] = occ_q[j] - 1'b1;
        default: occ_d[j] = occ_q[j];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_l_q  <= '0;
      has_q    <= '0;
      opnd_q   <= '0;
      wr_ptr_q <= '0;
      ack_r_q  <= '0;
      dout_q   <= '0;
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        rd_ptr_q[j] <= '0;
        occ_q[j]    <= '0;
      end
    end else begin
      req_l_q  <= req_l_d;
      has_q    <= has_d;
      opnd_q   <= opnd_d;
      wr_ptr_q <= wr_ptr_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        rd_ptr_q[j] <= rd_ptr_d[j];
        occ_q[j]    <= occ_d[j];
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (fire) mem_q[wr_ptr_q] <= alu_res;
  end

  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = dout_q;

`ifdef ASYNC_OP_STATS_EN
  logic [31:0] fire_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && fire_cnt_q != '1) fire_cnt_q <= fire_cnt_q + 1'b1;
      if (all_has && full && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fire_count  = fire_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_operator_buffered.sv
// Directed bench: ADDI latency, 3-operand SUB, two-consumer backpressure and async reset.
module tb_async_operator_buffered;
  import async_op_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        addi_req_l, addi_ack_l, addi_req_r, addi_ack_r;
  logic [31:0] addi_din, addi_dout;
  logic [2:0]  sub_req_l, sub_ack_l;
  logic [95:0] sub_din;
  logic        sub_req_r, sub_ack_r;
  logic [31:0] sub_dout;
  logic        fan_req_l, fan_ack_l;
  logic [31:0] fan_din;
  logic [1:0]  fan_req_r, fan_ack_r;
  logic [63:0] fan_dout;
`ifdef ASYNC_OP_STATS_EN
  logic [31:0] addi_fire, addi_stall, sub_fire, sub_stall, fan_fire, fan_stall;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  logic [31:0] exp_q[$];

  async_operator_buffered #(.OP(OP_ADDI), .IMMEDIATE(32'd2)) u_addi (
    .clk(clk), .rst(rst), .req_l(addi_req_l), .ack_l(addi_ack_l), .din(addi_din),
    .req_r(addi_req_r), .ack_r(addi_ack_r), .dout(addi_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(addi_fire), .stall_count(addi_stall)
`endif
  );

  async_operator_buffered #(.OP(OP_SUB), .INPUT_SIZE(3)) u_sub (
    .clk(clk), .rst(rst), .req_l(sub_req_l), .ack_l(sub_ack_l), .din(sub_din),
    .req_r(sub_req_r), .ack_r(sub_ack_r), .dout(sub_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(sub_fire), .stall_count(sub_stall)
`endif
  );

  async_operator_buffered #(.OP(OP_MULI), .IMMEDIATE(32'd3), .OUTPUT_SIZE(2), .DEPTH(4)) u_fan (
    .clk(clk), .rst(rst), .req_l(fan_req_l), .ack_l(fan_ack_l), .din(fan_din),
    .req_r(fan_req_r), .ack_r(fan_ack_r), .dout(fan_dout)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(fan_fire), .stall_count(fan_stall)
`endif
  );

  // Collects every value handed to each fan-out consumer.
  always @(negedge clk) begin
    if (fan_ack_r[0]) got0.push_back(fan_dout[31:0]);
    if (fan_ack_r[1]) got1.push_back(fan_dout[63:32]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_got(input string tag, input int which);
    logic [31:0] q[$];
    if (which == 0) q = got0;
    else            q = got1;
    check({tag, "_size"}, 64'(q.size()), 64'(exp_q.size()));
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) check(tag, q[i], exp_q[i]);
  endtask

  task automatic send_addi(input logic [31:0] v);
    int n;
    n = 0;
    while (addi_req_l !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("addi_req_l_up", addi_req_l, 1'b1);
    addi_ack_l = 1'b1; addi_din = v;
    @(negedge clk);
    addi_ack_l = 1'b0;
  endtask

  task automatic wait_addi_ack();
    int n;
    n = 0;
    while (addi_ack_r !== 1'b1 && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic send_sub(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    int n;
    n = 0;
    while (sub_req_l !== 3'b111 && n < 20) begin @(negedge clk); n++; end
    check("sub_req_l_up", sub_req_l, 3'b111);
    sub_ack_l = 3'b111; sub_din = {d2, d1, d0};
    @(negedge clk);
    sub_ack_l = 3'b000;
  endtask

  task automatic wait_sub_ack();
    int n;
    n = 0;
    while (sub_ack_r !== 1'b1 && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic send_fan(input logic [31:0] v);
    int n;
    n = 0;
    while (fan_req_l !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("fan_req_l_up", fan_req_l, 1'b1);
    fan_ack_l = 1'b1; fan_din = v;
    @(negedge clk);
    fan_ack_l = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    addi_ack_l = 1'b0; addi_din = '0; addi_req_r = 1'b0;
    sub_ack_l = '0; sub_din = '0; sub_req_r = 1'b0;
    fan_ack_l = 1'b0; fan_din = '0; fan_req_r = '0;
    #3;
    check("rst_addi_req_l", addi_req_l, 1'b0);
    check("rst_addi_ack_r", addi_ack_r, 1'b0);
    check("rst_addi_dout", addi_dout, 32'd0);
    check("rst_sub_req_l", sub_req_l, 3'b000);
    check("rst_fan_ack_r", fan_ack_r, 2'b00);
    check("rst_fan_dout", fan_dout, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rel_addi_req_l_low", addi_req_l, 1'b0);
    @(negedge clk);
    check("rel_addi_req_l_high", addi_req_l, 1'b1);
    check("rel_sub_req_l_high", sub_req_l, 3'b111);

    // ADDI: ack_l on edge k, ack_r on edge k+2; an ack_l while req_l is low is dropped.
    addi_ack_l = 1'b1; addi_din = 32'd5; addi_req_r = 1'b1;
    @(negedge clk);
    check("addi_req_l_fell", addi_req_l, 1'b0);
    check("addi_ack_r_k", addi_ack_r, 1'b0);
    addi_din = 32'd100;
    @(negedge clk);
    addi_ack_l = 1'b0;
    check("addi_ack_r_k1", addi_ack_r, 1'b0);
    @(negedge clk);
    check("addi_ack_r_k2", addi_ack_r, 1'b1);
    check("addi_dout_7", addi_dout, 32'd7);
    check("addi_req_l_again", addi_req_l, 1'b1);
    @(negedge clk);
    check("addi_ack_r_pulse", addi_ack_r, 1'b0);
    send_addi(32'd9);
    wait_addi_ack();
    check("addi_ack_r_2nd", addi_ack_r, 1'b1);
    check("addi_dout_11", addi_dout, 32'd11);

    // SUB over three operands, including wrap-around and staggered arrivals.
    sub_req_r = 1'b1;
    send_sub(32'd10, 32'd3, 32'd2);
    wait_sub_ack();
    check("sub_ack_5", sub_ack_r, 1'b1);
    check("sub_dout_5", sub_dout, 32'd5);
    send_sub(32'd0, 32'd1, 32'd0);
    wait_sub_ack();
    check("sub_ack_wrap", sub_ack_r, 1'b1);
    check("sub_dout_wrap", sub_dout, 32'hFFFF_FFFF);
    send_sub(32'd0, 32'd0, 32'd0);
    wait_sub_ack();
    check("sub_dout_zero", sub_dout, 32'd0);
    repeat (2) @(negedge clk);
    check("sub_req_l_idle", sub_req_l, 3'b111);
    sub_ack_l = 3'b001; sub_din = {32'd0, 32'd0, 32'd100};
    @(negedge clk);
    sub_ack_l = 3'b000;
    @(negedge clk);
    sub_ack_l = 3'b100; sub_din = {32'd50, 32'd0, 32'd0};
    @(negedge clk);
    sub_ack_l = 3'b000;
    @(negedge clk);
    check("sub_partial_req_l", sub_req_l, 3'b010);
    check("sub_partial_no_ack", sub_ack_r, 1'b0);
    sub_ack_l = 3'b010; sub_din = {32'd0, 32'd20, 32'd0};
    @(negedge clk);
    sub_ack_l = 3'b000;
    wait_sub_ack();
    check("sub_dout_stagger", sub_dout, 32'd30);

    // Fan-out: consumer 1 stalled until the buffer fills, then released.
    fan_req_r = 2'b01;
    for (int v = 1; v <= 4; v++) send_fan(32'(v));
    repeat (6) @(negedge clk);
    exp_q = {32'd3, 32'd6, 32'd9, 32'd12};
    check_got("fan_c0_first4", 0);
    check("fan_c1_none", 64'(got1.size()), 64'd0);
    send_fan(32'd5);
    repeat (10) @(negedge clk);
    check("fan_no_fifth_fire", 64'(got0.size()), 64'd4);
`ifdef ASYNC_OP_STATS_EN
    check("fan_fire_count_4", fan_fire, 32'd4);
    check("fan_stall_count_10", fan_stall, 32'd10);
`endif
    fan_req_r = 2'b11;
    @(negedge clk);
    check("fan_c1_first_ack", fan_ack_r, 2'b10);
    check("fan_c1_first_val", fan_dout[63:32], 32'd3);
`ifdef ASYNC_OP_STATS_EN
    check("fan_fire_count_p1", fan_fire, 32'd4);
`endif
    @(negedge clk);
    check("fan_c0_no_ack_p2", fan_ack_r[0], 1'b0);
`ifdef ASYNC_OP_STATS_EN
    check("fan_fire_count_p2", fan_fire, 32'd5);
`endif
    @(negedge clk);
    check("fan_c0_ack_p3", fan_ack_r[0], 1'b1);
    check("fan_c0_fifth", fan_dout[31:0], 32'd15);
    repeat (12) @(negedge clk);
    exp_q = {32'd3, 32'd6, 32'd9, 32'd12, 32'd15};
    check_got("fan_c1_all", 1);
    check_got("fan_c0_all", 0);

    // Asynchronous reset with three entries buffered.
    fan_req_r = 2'b00;
    got0.delete(); got1.delete();
    send_fan(32'd7);
    send_fan(32'd8);
    send_fan(32'd9);
    repeat (3) @(negedge clk);
    fan_req_r = 2'b01;
    @(posedge clk);
    #1;
    check("pre_rst_ack", fan_ack_r, 2'b01);
    check("pre_rst_dout", fan_dout[31:0], 32'd21);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_ack_r", fan_ack_r, 2'b00);
    check("async_rst_dout", fan_dout, 64'd0);
    check("async_rst_req_l", fan_req_l, 1'b0);
`ifdef ASYNC_OP_STATS_EN
    check("async_rst_fire_count", fan_fire, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    fan_req_r = 2'b11;
    check("post_rst_req_l_low", fan_req_l, 1'b0);
    @(negedge clk);
    check("post_rst_req_l_high", fan_req_l, 1'b1);
    repeat (6) @(negedge clk);
    check("no_stale_c0", 64'(got0.size()), 64'd0);
    check("no_stale_c1", 64'(got1.size()), 64'd0);
    send_fan(32'd2);
    repeat (6) @(negedge clk);
    exp_q = {32'd6};
    check_got("post_rst_c0", 0);
    check_got("post_rst_c1", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
